// File: rtl/eth_egress_reader.sv
// ============================================================================
// Module      : eth_egress_reader
// Description : Output-port read engine. Pops the switch output queue, checks
//               sop/eop framing and presents a valid/ready packet stream.
//               Optional max-length check: ETH_EGR_MAX_LEN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module eth_egress_reader #(
    parameter int DATA_WIDTH    = 8,
    parameter int CNT_WIDTH     = 16,
    parameter int MAX_PKT_WORDS = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  port_stall_empty,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] outdata,
    input  logic                  outsop,
    input  logic                  outeop,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_sop,
    output logic                  m_eop,
    output logic                  m_err,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  pkt_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt
);

    localparam int c_EW = DATA_WIDTH + 3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PKT     = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_EW-1:0]       r_buf [4];
    logic [1:0]            r_wr_ptr;
    logic [1:0]            r_rd_ptr;
    logic [2:0]            r_count;
    logic                  r_pend;
    logic [CNT_WIDTH-1:0]  r_pkt_cnt;
    logic [CNT_WIDTH-1:0]  r_err_cnt;
    logic                  w_fwd;
    logic                  w_err_inc;
    logic                  w_weop;
    logic                  w_werr;
    logic                  w_pop;
    logic [c_EW-1:0]       w_head;

    // Credit: buffered words plus the one in flight must leave room for two more.
    assign rd_en = !rst && !port_stall_empty && ((r_count + {2'b00, r_pend}) <= 3'd2);

    assign w_head  = r_buf[r_rd_ptr];
    assign m_valid = !rst && (r_count != 3'd0);
    assign m_data  = rst ? '0 : w_head[c_EW-1:3];
    assign m_sop   = rst ? 1'b0 : w_head[2];
    assign m_eop   = rst ? 1'b0 : w_head[1];
    assign m_err   = rst ? 1'b0 : w_head[0];
    assign w_pop   = m_valid && m_ready;
    assign pkt_cnt = r_pkt_cnt;
    assign err_cnt = r_err_cnt;

`ifdef ETH_EGR_MAX_LEN_CHECK_EN
    localparam int c_WCW = $clog2(MAX_PKT_WORDS + 1);
    logic [c_WCW-1:0] r_wcnt;
    logic [c_WCW-1:0] w_wcnt_nxt;

    assign w_wcnt_nxt = outsop ? c_WCW'(1) : (r_wcnt + c_WCW'(1));

    always_ff @(posedge clk) begin
        if (rst)
            r_wcnt <= '0;
        else if (r_pend && w_fwd)
            r_wcnt <= w_wcnt_nxt;
    end
`else
    logic w_unused_max_len;
    assign w_unused_max_len = (MAX_PKT_WORDS > 0);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_fwd       = 1'b0;
        w_err_inc   = 1'b0;
        w_werr      = 1'b0;
        w_weop      = outeop;
        if (r_pend) begin
            case (r_state)
                S_PKT: begin
                    w_fwd = 1'b1;
                    if (outsop) begin
                        // New sop truncates the open packet; flag the new head.
                        w_err_inc   = 1'b1;
                        w_werr      = 1'b1;
                        w_state_nxt = outeop ? S_IDLE : S_PKT;
                    end else if (outeop) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_DISCARD: begin
                    if (outsop) begin
                        w_err_inc   = 1'b1;
                        w_fwd       = 1'b1;
                        w_state_nxt = outeop ? S_IDLE : S_PKT;
                    end else if (outeop) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    if (outsop) begin
                        w_fwd       = 1'b1;
                        w_state_nxt = outeop ? S_IDLE : S_PKT;
                    end else begin
                        w_err_inc   = 1'b1;
                        w_state_nxt = outeop ? S_IDLE : S_DISCARD;
                    end
                end
            endcase
`ifdef ETH_EGR_MAX_LEN_CHECK_EN
            if (w_fwd && !outeop && (w_wcnt_nxt == c_WCW'(MAX_PKT_WORDS))) begin
                w_weop      = 1'b1;
                w_werr      = 1'b1;
                w_err_inc   = 1'b1;
                w_state_nxt = S_DISCARD;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pend    <= 1'b0;
            r_wr_ptr  <= 2'd0;
            r_rd_ptr  <= 2'd0;
            r_count   <= 3'd0;
            r_pkt_cnt <= '0;
            r_err_cnt <= '0;
            for (int i = 0; i < 4; i++)
                r_buf[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= rd_en;
            if (w_fwd) begin
                r_buf[r_wr_ptr] <= {outdata, outsop, w_weop, w_werr};
                r_wr_ptr        <= r_wr_ptr + 2'd1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 2'd1;
            case ({w_fwd, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
            if (w_fwd && w_weop && (r_pkt_cnt != {CNT_WIDTH{1'b1}}))
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
            if (w_err_inc && (r_err_cnt != {CNT_WIDTH{1'b1}}))
                r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_eth_egress_reader.sv
// ============================================================================
// Module      : tb_eth_egress_reader
// Description : Directed self-checking bench for eth_egress_reader with a
//               behavioural switch output queue feeding the read side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_eth_egress_reader;

    localparam int DW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          port_stall_empty;
    logic          rd_en;
    logic [DW-1:0] outdata;
    logic          outsop;
    logic          outeop;
    logic [DW-1:0] m_data;
    logic          m_sop;
    logic          m_eop;
    logic          m_err;
    logic          m_valid;
    logic          m_ready;
    logic [CW-1:0] pkt_cnt;
    logic [CW-1:0] err_cnt;

    always #5 clk = ~clk;

    eth_egress_reader #(
        .DATA_WIDTH    (DW),
        .CNT_WIDTH     (CW),
        .MAX_PKT_WORDS (4)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .port_stall_empty (port_stall_empty),
        .rd_en            (rd_en),
        .outdata          (outdata),
        .outsop           (outsop),
        .outeop           (outeop),
        .m_data           (m_data),
        .m_sop            (m_sop),
        .m_eop            (m_eop),
        .m_err            (m_err),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .pkt_cnt          (pkt_cnt),
        .err_cnt          (err_cnt)
    );

    logic [DW-1:0] qd [64];
    logic          qs [64];
    logic          qe [64];
    int            qlen, qptr;
    logic [10:0]   lg [64];
    int            lglen;
    int            cyc, rd_cnt, first_rd, first_v, last_v, v_cnt;
    int            n_vec, n_miss;

    // One clock: sample outputs at negedge, then model the queue after posedge.
    task automatic cycle();
        logic pop;
        @(negedge clk);
        pop = rd_en;
        if (rd_en) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (m_valid) begin
            v_cnt++;
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
        end
        if (m_valid && m_ready && lglen < 64) begin
            lg[lglen] = {m_data, m_sop, m_eop, m_err};
            lglen++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pop && qptr < qlen) begin
            outdata = qd[qptr];
            outsop  = qs[qptr];
            outeop  = qe[qptr];
            qptr++;
        end else begin
            outdata = '0;
            outsop  = 1'b0;
            outeop  = 1'b0;
        end
        port_stall_empty = (qptr >= qlen);
    endtask

    task automatic push(input logic [DW-1:0] d, input logic s, input logic e);
        qd[qlen] = d;
        qs[qlen] = s;
        qe[qlen] = e;
        qlen++;
        port_stall_empty = 1'b0;
    endtask

    task automatic clear_stats();
        rd_cnt = 0; first_rd = -1; first_v = -1; last_v = -1; v_cnt = 0; lglen = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        qlen = 0; qptr = 0;
        port_stall_empty = 1'b1;
        outdata = '0; outsop = 1'b0; outeop = 1'b0;
        m_ready = 1'b1;
        cycle();
        rst = 1'b0;
        clear_stats();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        n_vec++;
        if ({rd_en, m_valid, m_sop, m_eop, m_err} !== 5'b0) begin
            n_miss++;
            $display("FAIL reset_ctl got=%b exp=00000", {rd_en, m_valid, m_sop, m_eop, m_err});
        end
        n_vec++;
        if (m_data !== '0) begin
            n_miss++;
            $display("FAIL reset_data got=%h exp=00", m_data);
        end
        n_vec++;
        if (pkt_cnt !== '0 || err_cnt !== '0) begin
            n_miss++;
            $display("FAIL reset_cnt got=%0d/%0d exp=0/0", pkt_cnt, err_cnt);
        end
        rst = 1'b0;
        cycle();
        n_vec++;
        if (m_valid !== 1'b0 || rd_en !== 1'b0) begin
            n_miss++;
            $display("FAIL post_reset_idle got=%b%b exp=00", m_valid, rd_en);
        end
    endtask

    task automatic test_basic();
        logic [10:0] exp [4];
        do_reset();
        exp[0] = {8'h11, 3'b100}; exp[1] = {8'h12, 3'b000};
        exp[2] = {8'h13, 3'b000}; exp[3] = {8'h14, 3'b010};
        push(8'h11, 1, 0); push(8'h12, 0, 0); push(8'h13, 0, 0); push(8'h14, 0, 1);
        repeat (12) cycle();
        n_vec++;
        if (rd_cnt !== 4) begin n_miss++; $display("FAIL basic_rd_cycles got=%0d exp=4", rd_cnt); end
        n_vec++;
        if (first_v - first_rd !== 2) begin
            n_miss++; $display("FAIL basic_latency got=%0d exp=2", first_v - first_rd);
        end
        n_vec++;
        if (v_cnt !== 4 || last_v - first_v !== 3) begin
            n_miss++; $display("FAIL basic_valid_run got=%0d span=%0d exp=4 span=3", v_cnt, last_v - first_v);
        end
        n_vec++;
        if (lglen !== 4) begin n_miss++; $display("FAIL basic_len got=%0d exp=4", lglen); end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (lg[i] !== exp[i]) begin
                n_miss++; $display("FAIL basic_word%0d got=%h exp=%h", i, lg[i], exp[i]);
            end
        end
        n_vec++;
        if (pkt_cnt !== 16'd1 || err_cnt !== 16'd0) begin
            n_miss++; $display("FAIL basic_cnt got=%0d/%0d exp=1/0", pkt_cnt, err_cnt);
        end
    endtask

    task automatic test_stall();
        logic [10:0] exp [4];
        int stall_bad;
        do_reset();
        exp[0] = {8'h11, 3'b100}; exp[1] = {8'h12, 3'b000};
        exp[2] = {8'h13, 3'b000}; exp[3] = {8'h14, 3'b010};
        m_ready = 1'b0;
        stall_bad = 0;
        push(8'h11, 1, 0); push(8'h12, 0, 0); push(8'h13, 0, 0); push(8'h14, 0, 1);
        repeat (10) begin
            cycle();
            if (m_valid && {m_data, m_sop} !== {8'h11, 1'b1}) stall_bad++;
        end
        n_vec++;
        if (rd_cnt !== 3) begin n_miss++; $display("FAIL stall_rd_cycles got=%0d exp=3", rd_cnt); end
        n_vec++;
        if (stall_bad !== 0 || m_valid !== 1'b1) begin
            n_miss++; $display("FAIL stall_head_stable got=%0d bad valid=%b exp=0 bad valid=1", stall_bad, m_valid);
        end
        m_ready = 1'b1;
        repeat (10) cycle();
        n_vec++;
        if (lglen !== 4 || rd_cnt !== 4) begin
            n_miss++; $display("FAIL stall_len got=%0d rd=%0d exp=4 rd=4", lglen, rd_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (lg[i] !== exp[i]) begin
                n_miss++; $display("FAIL stall_word%0d got=%h exp=%h", i, lg[i], exp[i]);
            end
        end
    endtask

    task automatic test_headless();
        do_reset();
        push(8'hA0, 0, 0); push(8'hA1, 0, 1); push(8'hB0, 1, 1);
        repeat (12) cycle();
        n_vec++;
        if (lglen !== 1) begin n_miss++; $display("FAIL headless_len got=%0d exp=1", lglen); end
        n_vec++;
        if (lg[0] !== {8'hB0, 3'b110}) begin
            n_miss++; $display("FAIL headless_word got=%h exp=%h", lg[0], {8'hB0, 3'b110});
        end
        n_vec++;
        if (pkt_cnt !== 16'd1 || err_cnt !== 16'd1) begin
            n_miss++; $display("FAIL headless_cnt got=%0d/%0d exp=1/1", pkt_cnt, err_cnt);
        end
    endtask

    task automatic test_truncate();
        logic [10:0] exp [4];
        do_reset();
        exp[0] = {8'h01, 3'b100}; exp[1] = {8'h02, 3'b000};
        exp[2] = {8'h03, 3'b101}; exp[3] = {8'h04, 3'b010};
        push(8'h01, 1, 0); push(8'h02, 0, 0); push(8'h03, 1, 0); push(8'h04, 0, 1);
        repeat (12) cycle();
        n_vec++;
        if (lglen !== 4) begin n_miss++; $display("FAIL trunc_len got=%0d exp=4", lglen); end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (lg[i] !== exp[i]) begin
                n_miss++; $display("FAIL trunc_word%0d got=%h exp=%h", i, lg[i], exp[i]);
            end
        end
        n_vec++;
        if (pkt_cnt !== 16'd1 || err_cnt !== 16'd1) begin
            n_miss++; $display("FAIL trunc_cnt got=%0d/%0d exp=1/1", pkt_cnt, err_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push(8'h01, 1, 0); push(8'h02, 0, 0); push(8'h03, 0, 0); push(8'h04, 0, 1);
        push(8'h10, 1, 1);
        repeat (3) cycle();
        rst = 1'b1;
        #1;
        n_vec++;
        if (rd_en !== 1'b0 || m_valid !== 1'b0) begin
            n_miss++; $display("FAIL midrst_during got=%b%b exp=00", rd_en, m_valid);
        end
        cycle();
        rst = 1'b0;
        #1;
        n_vec++;
        if ({m_valid, m_sop, m_eop, m_err} !== 4'b0 || m_data !== '0) begin
            n_miss++; $display("FAIL midrst_after got=%b data=%h exp=0000 data=00", {m_valid, m_sop, m_eop, m_err}, m_data);
        end
        n_vec++;
        if (pkt_cnt !== '0 || err_cnt !== '0) begin
            n_miss++; $display("FAIL midrst_cnt got=%0d/%0d exp=0/0", pkt_cnt, err_cnt);
        end
        repeat (12) cycle();
        n_vec++;
        if (lglen !== 2) begin n_miss++; $display("FAIL midrst_len got=%0d exp=2", lglen); end
        n_vec++;
        if (lg[0] !== {8'h01, 3'b100} || lg[1] !== {8'h10, 3'b110}) begin
            n_miss++; $display("FAIL midrst_words got=%h,%h exp=%h,%h", lg[0], lg[1], {8'h01, 3'b100}, {8'h10, 3'b110});
        end
        n_vec++;
        if (pkt_cnt !== 16'd1 || err_cnt !== 16'd1) begin
            n_miss++; $display("FAIL midrst_cnt2 got=%0d/%0d exp=1/1", pkt_cnt, err_cnt);
        end
    endtask

    task automatic test_length();
        logic [10:0] exp [6];
        do_reset();
        push(8'h21, 1, 0); push(8'h22, 0, 0); push(8'h23, 0, 0);
        push(8'h24, 0, 0); push(8'h25, 0, 0); push(8'h26, 0, 1);
        exp[0] = {8'h21, 3'b100}; exp[1] = {8'h22, 3'b000}; exp[2] = {8'h23, 3'b000};
`ifdef ETH_EGR_MAX_LEN_CHECK_EN
        exp[3] = {8'h24, 3'b011}; exp[4] = '0; exp[5] = '0;
`else
        exp[3] = {8'h24, 3'b000}; exp[4] = {8'h25, 3'b000}; exp[5] = {8'h26, 3'b010};
`endif
        repeat (16) cycle();
`ifdef ETH_EGR_MAX_LEN_CHECK_EN
        n_vec++;
        if (lglen !== 4) begin n_miss++; $display("FAIL maxlen_len got=%0d exp=4", lglen); end
        n_vec++;
        if (pkt_cnt !== 16'd1 || err_cnt !== 16'd1) begin
            n_miss++; $display("FAIL maxlen_cnt got=%0d/%0d exp=1/1", pkt_cnt, err_cnt);
        end
        for (int i = 0; i < 4; i++) begin
`else
        n_vec++;
        if (lglen !== 6) begin n_miss++; $display("FAIL longpkt_len got=%0d exp=6", lglen); end
        n_vec++;
        if (pkt_cnt !== 16'd1 || err_cnt !== 16'd0) begin
            n_miss++; $display("FAIL longpkt_cnt got=%0d/%0d exp=1/0", pkt_cnt, err_cnt);
        end
        for (int i = 0; i < 6; i++) begin
`endif
            n_vec++;
            if (lg[i] !== exp[i]) begin
                n_miss++; $display("FAIL length_word%0d got=%h exp=%h", i, lg[i], exp[i]);
            end
        end
    endtask

    initial begin
        n_vec = 0; n_miss = 0; cyc = 0;
        rst = 1'b1; m_ready = 1'b0; port_stall_empty = 1'b1;
        outdata = '0; outsop = 1'b0; outeop = 1'b0;
        qlen = 0; qptr = 0;
        clear_stats();
        test_reset();
        test_basic();
        test_stall();
        test_headless();
        test_truncate();
        test_reset_mid();
        test_length();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/eth_egress_reader.md
Name: eth_egress_reader

Overview:
- Read-side engine for one output port of the 2x2 switch. One instance per port.
- Pops words from the port's output queue with rd_en while the queue is not empty.
- Checks sop/eop framing, buffers words, and presents them as a valid/ready packet stream to the downstream sink.
- Keeps saturating packet and error counters.

Parameters:
- DATA_WIDTH, 8, width of the switch data bus.
- CNT_WIDTH, 16, width of the pkt_cnt and err_cnt statistics counters.
- MAX_PKT_WORDS, 64, maximum words per packet. Used only when the optional feature is compiled in.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- port_stall_empty  in  1  switch output queue empty.
- rd_en  out  1  pop request to the switch output queue.
- outdata  in  DATA_WIDTH  queue data; valid one cycle after rd_en.
- outsop  in  1  start-of-packet marker, same timing as outdata.
- outeop  in  1  end-of-packet marker, same timing as outdata.
- m_data  out  DATA_WIDTH  downstream data.
- m_sop  out  1  downstream start of packet.
- m_eop  out  1  downstream end of packet.
- m_err  out  1  word carries a framing or length error flag.
- m_valid  out  1  downstream word valid.
- m_ready  in  1  downstream accept.
- pkt_cnt  out  CNT_WIDTH  count of packets forwarded with eop.
- err_cnt  out  CNT_WIDTH  count of framing and length errors.

Behaviour:
- Clock and reset:
  - Single clock domain clk. rst is synchronous and active-high.
  - Reset clears: 4-entry output buffer, pend flag, FSM (to IDLE), word counter, pkt_cnt, err_cnt.
  - All outputs are 0 during and after reset, including rd_en, m_valid, m_data, m_sop, m_eop and m_err.
- Read side:
  - rd_en = !rst && !port_stall_empty && (count + pend) <= 2.
  - count is buffer occupancy (0..4). pend is a register equal to the previous cycle's rd_en.
  - rd_en is driven from registered state and port_stall_empty only. There is no path from m_ready.
  - With m_ready held high, the reader sustains 1 word/cycle.
- Capture:
  - When pend=1, outdata, outsop and outeop are sampled in that cycle, regardless of port_stall_empty.
  - The sampled word goes to the framing FSM. A forwarded word is written to the buffer in the same cycle.
- Downstream handshake:
  - m_valid=1 whenever the buffer is non-empty. m_data, m_sop, m_eop and m_err show the head entry.
  - A word pops when m_valid && m_ready.
  - Head outputs are stable while m_valid && !m_ready.
  - A push and a pop in the same cycle leave count unchanged.
  - The buffer never overflows; the rd_en credit rule guarantees this.
- Framing FSM, states IDLE / PKT / DISCARD:
  - IDLE, sop=1: forward the word. If eop=1 (single-word packet), stay in IDLE; otherwise go to PKT.
  - IDLE, sop=0: err_cnt+1 and drop the word. If eop=0, go to DISCARD; otherwise stay in IDLE.
  - PKT, sop=0: forward the word. If eop=1, go to IDLE.
  - PKT, sop=1: err_cnt+1. The previous packet is truncated. Forward this word with m_sop=1 and m_err=1. Go to IDLE if eop=1, else stay in PKT.
  - DISCARD, sop=0: drop the word. If eop=1, go to IDLE.
  - DISCARD, sop=1: err_cnt+1. Handle the word as a new packet start, exactly as the IDLE sop=1 case.
- Counters:
  - pkt_cnt+1 when a word with eop=1 is written into the buffer.
  - pkt_cnt and err_cnt saturate at all-ones and do not wrap.
  - At most one increment per counter per cycle.
- Reset mid-packet: any word in flight (pend) is discarded. The FSM returns to IDLE, so the next word must carry sop.

Optional Feature:
- Macro: ETH_EGR_MAX_LEN_CHECK_EN.
- Defined:
  - A word counter counts forwarded words of the current packet; it is 1 on the sop word.
  - If the counter reaches MAX_PKT_WORDS on a word with eop=0, that word is forwarded with m_eop=1 and m_err=1.
  - That event increments both err_cnt and pkt_cnt, and the FSM goes to DISCARD.
- Undefined: there is no length limit and no word-counter logic; MAX_PKT_WORDS is ignored.

Test Plan:
- Reset, then a 4-word packet 0x11..0x14 (sop on 0x11, eop on 0x14), m_ready=1:
  - rd_en is high for 4 cycles.
  - m_valid is high for 4 consecutive cycles, the first one 2 cycles after the first rd_en.
  - Words 0x11..0x14 appear in order with correct sop/eop; pkt_cnt=1, err_cnt=0.
- Same packet with m_ready=0 for 10 cycles, then m_ready=1:
  - rd_en stops after 3 pops, leaving buffer + pend at 3 words.
  - Head word 0x11 stays stable throughout the stall; all 4 words are delivered with no loss or duplication.
- Headless burst (0xA0 with sop=0, then 0xA1 with eop=1), followed by a valid 1-word packet 0xB0 (sop=eop=1):
  - Only 0xB0 is delivered; err_cnt=1, pkt_cnt=1.
- Packet 0x01, 0x02 with no eop, then sop on 0x03 with eop on 0x04:
  - Output is 0x01, 0x02, then 0x03 with m_sop=1 and m_err=1, then 0x04 with m_eop=1.
  - err_cnt=1, pkt_cnt=1.
- Assert rst for 1 cycle in the middle of a packet:
  - All outputs are 0 in the following cycle.
  - Remaining non-sop words are not forwarded; the next sop packet is delivered cleanly.
- Macro defined, MAX_PKT_WORDS=4, 6-word packet:
  - 4 words delivered; the 4th has m_eop=1 and m_err=1.
  - Words 5 and 6 are dropped; err_cnt=1, pkt_cnt=1.
